sequence_generator: RTL and testbench
=====================================

# sequence_generator

Serial pattern transmitter that drives the single-bit `x` stream consumed by the 1011 sequence detector. On a `start` request it latches a W-bit pattern and shifts it out MSB-first, one bit per clock. It can repeat the frame a programmed number of times, with an optional idle gap between frames. It is the stimulus source for detector loopback tests and the transmit end of the serial pattern link.

## Interface
- `W`, default 4: pattern width in bits (W ≥ 2).
- `CNT_W`, default 4: width of the repeat and gap counters.
- `IDLE_BIT`, default 1'b0: value driven on `x` whenever `x_valid` = 0.
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `start`  in  1: request to begin a transmission; sampled only in IDLE.
- `abort`  in  1: synchronous cancel; takes priority over every other input except `reset`.
- `pattern`  in  W: frame bits; `pattern[W-1]` is sent first; sampled on the accepted `start`.
- `repeat_n`  in  CNT_W: additional frames after the first (total frames = `repeat_n` + 1); sampled on start.
- `gap_len`  in  CNT_W: idle cycles inserted between frames; 0 means back-to-back frames; sampled on start.
- `x`  out  1: registered serial bit.
- `x_valid`  out  1: high while `x` carries a pattern bit.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse after the last bit of the last frame.
- `state`  out  2: current FSM encoding, for debug/observation.

## Operation
- States: IDLE=2'b00, SEND=2'b01, GAP=2'b10, DONE=2'b11.
- IDLE:
  - On `start`=1, latch `pattern` into the shift register, `repeat_n` into `rep_left` and `gap_len` into `gap_cfg`.
  - Set `bit_cnt` = W-1 and go to SEND.
- SEND:
  - `x` = shift register MSB and `x_valid` = 1; shift left each cycle.
  - `bit_cnt` decrements each cycle.
  - When `bit_cnt` = 0 (last bit of the frame):
    - If `rep_left` = 0, go to DONE.
    - Else decrement `rep_left` and reload the shift register from the latched copy of `pattern`.
    - Then go to GAP if `gap_cfg` ≠ 0, else stay in SEND with `bit_cnt` = W-1.
- GAP:
  - `x` = `IDLE_BIT` and `x_valid` = 0 for exactly `gap_cfg` cycles.
  - Then go to SEND with `bit_cnt` = W-1.
- DONE: `done` = 1 for one cycle, `busy` = 1, `x_valid` = 0; then go to IDLE unconditionally.
- `start` outside IDLE is ignored. Live input changes to `pattern`, `repeat_n` and `gap_len` after acceptance have no effect on the transmission in progress.
- `abort` = 1 in any non-IDLE state: next state is IDLE, `x_valid` drops, and no `done` pulse is produced. `abort` in IDLE is a no-op, and `abort` beats a simultaneous `start`.
- Counter arithmetic is unsigned CNT_W bits; `rep_left` never wraps because the decrement is gated by `rep_left` ≠ 0.
- `repeat_n` = 2^CNT_W − 1 is legal (maximum frame count).

## Timing
- Reset values:
  - `state` = IDLE, `x` = `IDLE_BIT`, `x_valid` = 0, `busy` = 0, `done` = 0.
  - Counters and the shift register = 0.
- Latency:
  - `start` accepted at edge k → first bit on `x` in the cycle after edge k.
  - Last bit at cycle k+W·(F)+(F−1)·`gap_len`, where F = `repeat_n` + 1.
  - `done` is high in the following cycle.
- Back-to-back frames with `gap_len` = 0 produce a continuous bit stream with no idle cycle.
- The earliest new `start` is accepted on the edge ending the first IDLE cycle after DONE; `start` held high therefore restarts with one idle cycle between runs.
- Async `reset` mid-frame forces the reset values immediately, with no `done` pulse.
- All outputs are registered; no combinational path from inputs to `x`.

## Structure
- Package `seq_gen_pkg`: the state enum/constants (IDLE, SEND, GAP, DONE) and the default pattern constant `PAT_1011` = 4'b1011.
- Sub-module `piso_shift_reg` (parameter W; load, shift enable, parallel in, serial MSB out, async active-high reset), instantiated once.
- FSM and counters live in the top module.

## Test plan
- `pattern` = 1011, `repeat_n` = 0, `gap_len` = 0, start pulse → `x_valid` high for 4 cycles carrying 1,0,1,1; `done` pulses in cycle 5; looped into the detector, `y` asserts exactly once.
- `pattern` = 1011, `repeat_n` = 2, `gap_len` = 0 → 12 contiguous valid bits 101110111011; `done` in cycle 13; the detector asserts `y` 3 times.
- `pattern` = 1011, `repeat_n` = 1, `gap_len` = 2 → 1011, then two cycles of `x_valid` = 0 with `x` = `IDLE_BIT`, then 1011; `done` in cycle 11.
- `start` pulsed during SEND with a different `pattern` (0110) → ignored; the original 1011 stream completes unchanged.
- `abort` on the 2nd bit of frame 1 with `repeat_n` = 3 → `state` = IDLE on the next cycle; `busy` = 0, no `done`; a subsequent start works normally.
- Async `reset` asserted mid-GAP, between clock edges → all outputs at reset values before the next edge; after release, a `start` yields a full correct frame.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared state encoding and default pattern for the serial sequence generator.
package seq_gen_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        GAP  = 2'b10,
        DONE = 2'b11
    } state_t;
    localparam logic [3:0] PAT_1011 = 4'b1011;
endpackage

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-in serial-out shift register, MSB first, zero fill.
module piso_shift_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);
    logic [W-1:0] sr;
    always_ff @(posedge clk or posedge reset)
        if (reset)      sr <= '0;
        else if (load)  sr <= din;
        else if (shift) sr <= {sr[W-2:0], 1'b0};
    assign msb = sr[W-1];
endmodule

// File: rtl/sequence_generator.sv
// sequence_generator: transmits a latched W-bit pattern MSB-first, repeated with optional idle gaps.
module sequence_generator
    import seq_gen_pkg::*;
#(
    parameter int   W        = 4,
    parameter int   CNT_W    = 4,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [W-1:0]     pattern,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic [CNT_W-1:0] gap_len,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);
    localparam int BW = $clog2(W);
    localparam logic [BW-1:0] LAST = BW'(W - 1);

    state_t state_q, state_d;
    logic [BW-1:0] bit_cnt;
    logic [CNT_W-1:0] rep_left, gap_cfg, gap_cnt;
    logic [W-1:0] pat_q, load_data;
    logic last, accept, sending, gapping, reload, load, shift, msb;

    assign last = bit_cnt == '0;

    always_ff @(posedge clk or posedge reset)
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? SEND : IDLE;
            SEND:    state_d = !last ? SEND : rep_left == '0 ? DONE : gap_cfg != '0 ? GAP : SEND;
            GAP:     state_d = gap_cnt == CNT_W'(1) ? SEND : GAP;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_comb begin
        accept    = state_q == IDLE && start && !abort;
        sending   = state_q == SEND && !abort;
        gapping   = state_q == GAP && !abort;
        reload    = sending && last && rep_left != '0;
        load      = accept || reload;
        shift     = sending && !last;
        load_data = accept ? pattern : pat_q;
    end

    // Frame parameters are captured once so live input changes cannot disturb a run.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            pat_q    <= '0;
            rep_left <= '0;
            gap_cfg  <= '0;
            gap_cnt  <= '0;
            bit_cnt  <= '0;
        end else if (accept) begin
            pat_q    <= pattern;
            rep_left <= repeat_n;
            gap_cfg  <= gap_len;
            bit_cnt  <= LAST;
        end else if (sending) begin
            bit_cnt <= last ? LAST : bit_cnt - 1'b1;
            if (reload) rep_left <= rep_left - 1'b1;
            if (last)   gap_cnt  <= gap_cfg;
        end else if (gapping) begin
            gap_cnt <= gap_cnt - 1'b1;
        end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            x_valid <= state_d == SEND;
            busy    <= state_d != IDLE;
            done    <= state_d == DONE;
        end

    piso_shift_reg #(.W(W)) u_piso (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .shift(shift),
        .din  (load_data),
        .msb  (msb)
    );

    assign x     = x_valid ? msb : IDLE_BIT;
    assign state = state_q;
endmodule

// File: tb/tb_sequence_generator.sv
// tb_sequence_generator: directed and randomized runs checked against a frame-list reference model.
module tb_sequence_generator;
    localparam int   W  = 4;
    localparam int   CW = 4;
    localparam logic IB = 1'b1;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
    logic [W-1:0] pattern = '0;
    logic [CW-1:0] repeat_n = '0, gap_len = '0;
    logic x, x_valid, busy, done;
    logic [1:0] state;
    int n_checks = 0, n_fail = 0;

    typedef struct packed {logic v; logic x; logic b; logic d; logic [1:0] s;} exp_t;
    exp_t q[$];
    localparam exp_t IDLE_EXP = {1'b0, IB, 1'b0, 1'b0, 2'b00};

    always #5 clk = ~clk;

    sequence_generator #(.W(W), .CNT_W(CW), .IDLE_BIT(IB)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .pattern(pattern),
        .repeat_n(repeat_n), .gap_len(gap_len), .x(x), .x_valid(x_valid),
        .busy(busy), .done(done), .state(state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_cycle(input string tag, input exp_t e);
        check({tag, " x_valid"}, 32'(x_valid), 32'(e.v));
        check({tag, " x"}, 32'(x), 32'(e.x));
        check({tag, " busy"}, 32'(busy), 32'(e.b));
        check({tag, " done"}, 32'(done), 32'(e.d));
        check({tag, " state"}, 32'(state), 32'(e.s));
    endtask

    // Expected per-cycle outputs from acceptance to the DONE pulse.
    task automatic build(input logic [W-1:0] pat, input int rep, input int gap);
        q.delete();
        for (int f = 0; f <= rep; f++) begin
            for (int i = W - 1; i >= 0; i--) q.push_back({1'b1, pat[i], 1'b1, 1'b0, 2'b01});
            if (f < rep) for (int g = 0; g < gap; g++) q.push_back({1'b0, IB, 1'b1, 1'b0, 2'b10});
        end
        q.push_back({1'b0, IB, 1'b1, 1'b1, 2'b11});
    endtask

    // Called #1 after a rising edge with the DUT idle.
    task automatic run(input string tag, input logic [W-1:0] pat, input int rep, input int gap,
                       input int abort_at, input int reset_at, input bit poke);
        pattern = pat; repeat_n = CW'(rep); gap_len = CW'(gap); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; pattern = W'($urandom); repeat_n = CW'($urandom); gap_len = CW'($urandom);
        build(pat, rep, gap);
        for (int j = 0; j < q.size(); j++) begin
            @(negedge clk);
            check_cycle($sformatf("%s c%0d", tag, j), q[j]);
            if (j == abort_at) abort = 1'b1;
            if (poke && j == 1) begin start = 1'b1; pattern = 4'b0110; end
            if (j == reset_at) begin
                #2 reset = 1'b1;
                #1 check_cycle({tag, " async_rst"}, IDLE_EXP);
                reset = 1'b0;
            end
            @(posedge clk); #1;
            abort = 1'b0; start = 1'b0;
            if (j == abort_at || j == reset_at) break;
        end
        @(negedge clk);
        check_cycle({tag, " after"}, IDLE_EXP);
        @(posedge clk); #1;
    endtask

    initial begin
        #2 check_cycle("reset", IDLE_EXP);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk); check_cycle("post_reset", IDLE_EXP);
        @(posedge clk); #1;
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1 abort = 1'b0; start = 1'b0;
        @(negedge clk); check_cycle("abort_beats_start", IDLE_EXP);
        @(posedge clk); #1;
        run("single", 4'b1011, 0, 0, -1, -1, 1'b0);
        run("rep2", 4'b1011, 2, 0, -1, -1, 1'b0);
        run("gap2", 4'b1011, 1, 2, -1, -1, 1'b0);
        run("poke", 4'b1011, 0, 0, -1, -1, 1'b1);
        run("abort", 4'b1011, 3, 1, 1, -1, 1'b0);
        run("after_abort", 4'b1011, 0, 0, -1, -1, 1'b0);
        run("rst_gap", 4'b1011, 1, 3, -1, W + 1, 1'b0);
        run("after_rst", 4'b1011, 0, 0, -1, -1, 1'b0);
        run("max_rep", 4'b1001, 15, 0, -1, -1, 1'b0);
        for (int r = 0; r < 25; r++) begin
            automatic int rep = $urandom_range(0, 3);
            automatic int gap = $urandom_range(0, 3);
            automatic int ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, W * (rep + 1) - 1) : -1;
            run($sformatf("rnd%0d", r), W'($urandom), rep, gap, ab, -1, 1'($urandom));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
